ptw_mem_responder: RTL and testbench
====================================

Name: ptw_mem_responder

Overview:
Memory-side responder for the page-table walker's PTE read port. It accepts walker reads (addr/ren), holds the walker with a stall while it fetches the 64-bit PTE over a req/gnt/rvalid memory bus, then presents the PTE on rdata. It sits between the walker and the shared data-memory or cache port and includes a small PTE buffer that is invalidated on satp change or sfence.

Parameters:
ADDR_W, 64, physical address width of walker and memory bus
DATA_W, 64, PTE width; fixed at 64 for Sv39
TIMEOUT, 255, cycles allowed between mem_req and mem_rvalid before an error response

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ptw_addr  in  ADDR_W  PTE address from walker
ptw_ren  in  1  walker read enable; held high for the whole walk
ptw_rdata  out  DATA_W  PTE returned to walker
ptw_stall  out  1  high = ptw_rdata not valid for current ptw_addr
flush  in  1  satp write or sfence.vma; invalidates buffered PTEs
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  8-byte-aligned request address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
mem_err  in  1  bus error, qualified by mem_rvalid
err_pulse  out  1  one-cycle pulse on bus error or timeout

Behaviour:
- Reset values: ptw_rdata=0, mem_req=0, mem_addr=0, err_pulse=0; state IDLE; result register invalid.
- Result register: valid bit, tag (ptw_addr[ADDR_W-1:3]), data.
- ptw_stall is combinational: ptw_ren & ~(res_valid & res_tag==ptw_addr[ADDR_W-1:3]). When ptw_ren=0, stall=0.
- ptw_rdata is driven from the result register and is stable while ptw_stall=0.
- States:
  - IDLE: if ptw_ren and miss, latch the address, set mem_req=1 and mem_addr={ptw_addr[ADDR_W-1:3],3'b0}, go to REQ.
  - REQ: hold mem_req and mem_addr until mem_gnt; on gnt drop mem_req, clear the timeout counter, go to WAIT. Same-cycle gnt and rvalid is legal: treat it as a WAIT completion.
  - WAIT: on mem_rvalid, fill the result register (tag = latched address) with data = mem_err ? 0 : mem_rdata, then return to IDLE. On error, also pulse err_pulse. A zero PTE has V=0, so the walker faults.
  - Timeout: after TIMEOUT cycles in WAIT with no rvalid, fill data=0, pulse err_pulse, go to DRAIN.
  - DRAIN: discard the late mem_rvalid, then go to IDLE.
- Hit latency is 0 cycles (no stall). Minimum miss latency, with gnt and rvalid in consecutive cycles: stall is high for 3 cycles after the address appears.
- Walker address change mid-miss (new level): the in-flight fetch completes and fills the register. The tag then mismatches, so a new miss starts next cycle. No abort on the bus.
- flush in IDLE: clears res_valid next cycle.
- flush in REQ/WAIT: set a drop flag. The response is consumed but not written, res_valid=0, and the flag clears on return to IDLE.
- flush and fill in the same cycle: flush wins (not written).
- Only one outstanding memory transaction at any time.
- rst mid-transaction: go to IDLE immediately. A stale rvalid arriving in IDLE is ignored. The bus guarantees no rvalid without a prior gnt after reset, so no further response is expected.

Optional Feature:
PTE_BUF_EN: when defined, the result register becomes a 4-entry fully associative PTE buffer with round-robin replacement. A lookup hit in any entry gives stall=0 and rdata from that entry. flush clears all valid bits. When not defined, the block uses a single result register as described above.

Decomposition:
- Shared package ptw_pkg holds:
  - state enum ptw_rsp_state_t {IDLE, REQ, WAIT, DRAIN}
  - constants PTE_BYTES=8 and PTE_ERR_VALUE=64'h0
  - pte_buf_entry_t struct {valid, tag, data}
- One natural sub-module: ptw_pte_buf, which provides lookup, fill, and flush for one or four entries; the top-level FSM is unchanged by the feature.

Test Plan:
- Miss then hit: ptw_ren=1, addr=0x8000_1008. Memory gives gnt at +1 and rvalid at +2 with data 0x2000_0401. Expect stall high for 3 cycles, then rdata=0x2000_0401 and stall=0. Re-present the same addr: stall=0 in the same cycle.
- Walk sequence: addrs 0x8000_1008 → 0x8000_2010 → 0x8000_3018. Expect exactly 3 mem_req handshakes with mem_addr matching and each PTE returned in order.
- Bus error: mem_err=1 with rvalid. Expect rdata=0, err_pulse high for exactly 1 cycle, stall=0.
- Timeout: no rvalid for 255 cycles. Expect rdata=0, err_pulse. A late rvalid with 0xDEAD is discarded and rdata stays 0.
- Flush mid-WAIT: assert flush, then rvalid with 0x1234. Expect no fill, stall stays high, and a new mem_req for the same addr.
- Reset mid-REQ: rst=1 for 1 cycle. Expect mem_req=0, ptw_rdata=0, state IDLE. A following miss completes normally.

Source files
------------

// File: rtl/ptw_mem_responder_pkg.sv
// ============================================================================
//  Package     : ptw_pkg
//  Description : Shared types and constants for the PTW memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ptw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } ptw_rsp_state_t;

    localparam int          PTE_BYTES     = 8;
    localparam logic [63:0] PTE_ERR_VALUE = 64'h0;

    // Tags are stored zero-extended so one entry type serves any ADDR_W up to 64
    localparam int PTE_TAG_MAX_W = 64;

    typedef struct packed {
        logic                     valid;
        logic [PTE_TAG_MAX_W-1:0] tag;
        logic [63:0]              data;
    } pte_buf_entry_t;

endpackage

`default_nettype wire

// File: rtl/ptw_mem_responder_if.sv
// ============================================================================
//  Interface   : ptw_mem_responder_if
//  Description : req/gnt/rvalid memory read bus between responder and memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ptw_mem_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        output mem_err
    );
endinterface

`default_nettype wire

// File: rtl/ptw_mem_responder_pte_buf.sv
// ============================================================================
//  Module      : ptw_pte_buf
//  Description : PTE result store with lookup/fill/flush. One entry by default;
//                four fully associative round-robin entries with PTE_BUF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ptw_pte_buf
    import ptw_pkg::*;
#(
    parameter int TAG_W  = 61,
    parameter int DATA_W = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    input  wire logic [TAG_W-1:0]  lookup_tag,
    output logic                   hit,
    output logic [DATA_W-1:0]      rdata,
    input  wire logic              fill_en,
    input  wire logic [TAG_W-1:0]  fill_tag,
    input  wire logic [DATA_W-1:0] fill_data
);

`ifdef PTE_BUF_EN
    localparam int c_ENTRIES = 4;
`else
    localparam int c_ENTRIES = 1;
`endif
    localparam int c_IDX_W = (c_ENTRIES > 1) ? $clog2(c_ENTRIES) : 1;

    pte_buf_entry_t               r_entry [c_ENTRIES];
    logic [PTE_TAG_MAX_W-1:0]     w_lookup_tag;
    logic [PTE_TAG_MAX_W-1:0]     w_fill_tag;
    logic [c_IDX_W-1:0]           w_victim;
    logic                         w_write;

    assign w_lookup_tag = PTE_TAG_MAX_W'(lookup_tag);
    assign w_fill_tag   = PTE_TAG_MAX_W'(fill_tag);
    // A flush in the same cycle as a fill discards the fill
    assign w_write      = fill_en & ~flush;

`ifdef PTE_BUF_EN
    logic [c_IDX_W-1:0] r_rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_write) begin
            r_rr <= r_rr + 1'b1;
        end
    end

    assign w_victim = r_rr;
`else
    assign w_victim = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_entry[i].valid <= 1'b0;
            end
        end else if (w_write) begin
            r_entry[w_victim] <= '{valid: 1'b1, tag: w_fill_tag, data: 64'(fill_data)};
        end
    end

    always_comb begin
        hit   = 1'b0;
        rdata = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            if (r_entry[i].valid && (r_entry[i].tag == w_lookup_tag)) begin
                hit   = 1'b1;
`ifdef PTE_BUF_EN
                rdata = DATA_W'(r_entry[i].data);
`endif
            end
        end
`ifndef PTE_BUF_EN
        rdata = DATA_W'(r_entry[0].data);
`endif
    end

endmodule

`default_nettype wire

// File: rtl/ptw_mem_responder.sv
// ============================================================================
//  Module      : ptw_mem_responder
//  Description : Serves page-table-walker PTE reads over a req/gnt/rvalid bus,
//                stalling the walker until the PTE is buffered. Define
//                PTE_BUF_EN for a 4-entry PTE buffer instead of one register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ptw_mem_responder
    import ptw_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] ptw_addr,
    input  wire logic              ptw_ren,
    output logic [DATA_W-1:0]      ptw_rdata,
    output logic                   ptw_stall,
    input  wire logic              flush,
    ptw_mem_responder_if.master    mem,
    output logic                   err_pulse
);

    localparam int c_OFF_W = $clog2(PTE_BYTES);
    localparam int c_TAG_W = ADDR_W - c_OFF_W;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    ptw_rsp_state_t       r_state;
    ptw_rsp_state_t       w_state_nxt;
    logic [c_TAG_W-1:0]   r_tag;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_drop;
    logic                 r_err_pulse;

    logic [c_TAG_W-1:0]   w_addr_tag;
    logic                 w_unused_addr_lsb;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_start;
    logic                 w_rsp;
    logic                 w_timeout;
    logic                 w_fill_en;
    logic [DATA_W-1:0]    w_fill_data;
    logic                 w_err;
    logic                 w_drop_set;

    assign w_addr_tag        = ptw_addr[ADDR_W-1:c_OFF_W];
    assign w_unused_addr_lsb = ^ptw_addr[c_OFF_W-1:0];
    assign w_miss            = ptw_ren & ~w_hit;
    assign ptw_stall         = w_miss;

    assign mem.mem_req  = (r_state == REQ);
    assign mem.mem_addr = {r_tag, {c_OFF_W{1'b0}}};
    assign err_pulse    = r_err_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_miss) w_state_nxt = REQ;
            // gnt with rvalid in the same cycle completes straight from REQ
            REQ:     if (mem.mem_gnt) w_state_nxt = mem.mem_rvalid ? IDLE : WAIT;
            WAIT: begin
                if (mem.mem_rvalid)            w_state_nxt = IDLE;
                else if (r_cnt == c_CNT_LAST)  w_state_nxt = DRAIN;
            end
            DRAIN:   if (mem.mem_rvalid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_rsp      = 1'b0;
        w_timeout  = 1'b0;
        w_drop_set = 1'b0;
        case (r_state)
            IDLE:  w_start = w_miss;
            REQ: begin
                w_rsp      = mem.mem_gnt & mem.mem_rvalid;
                w_drop_set = flush;
            end
            WAIT: begin
                w_rsp      = mem.mem_rvalid;
                w_timeout  = ~mem.mem_rvalid & (r_cnt == c_CNT_LAST);
                w_drop_set = flush;
            end
            default: ;
        endcase
        w_fill_en   = (w_rsp | w_timeout) & ~r_drop;
        w_fill_data = (w_timeout | mem.mem_err) ? DATA_W'(PTE_ERR_VALUE) : mem.mem_rdata;
        w_err       = w_timeout | (w_rsp & mem.mem_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag       <= '0;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            if (w_start) begin
                r_tag <= w_addr_tag;
            end
            if ((r_state == REQ) && mem.mem_gnt) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A flush while a fetch is in flight makes its response stale
            if (w_state_nxt == IDLE) begin
                r_drop <= 1'b0;
            end else if (w_drop_set) begin
                r_drop <= 1'b1;
            end
            r_err_pulse <= w_err;
        end
    end

    ptw_pte_buf #(
        .TAG_W  (c_TAG_W),
        .DATA_W (DATA_W)
    ) u_pte_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .lookup_tag (w_addr_tag),
        .hit        (w_hit),
        .rdata      (ptw_rdata),
        .fill_en    (w_fill_en),
        .fill_tag   (r_tag),
        .fill_data  (w_fill_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_ptw_mem_responder.sv
// ============================================================================
//  Module      : tb_ptw_mem_responder
//  Description : Directed self-checking bench for ptw_mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ptw_mem_responder;

    logic        clk;
    logic        rst;
    logic [63:0] ptw_addr;
    logic        ptw_ren;
    logic [63:0] ptw_rdata;
    logic        ptw_stall;
    logic        flush;
    logic        err_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    ptw_mem_responder_if #(.ADDR_W(64), .DATA_W(64)) mif ();

    ptw_mem_responder #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ptw_addr  (ptw_addr),
        .ptw_ren   (ptw_ren),
        .ptw_rdata (ptw_rdata),
        .ptw_stall (ptw_stall),
        .flush     (flush),
        .mem       (mif.master),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [63:0] addr;
        logic        gnt;
        logic        rv;
        logic        merr;
        logic [63:0] mdata;
        logic        flush;
        logic        exp_stall;
        logic        exp_req;
        logic [63:0] exp_maddr;
        logic        chk_rd;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic r, input logic [63:0] a, input logic g, input logic v,
                                input logic e, input logic [63:0] d, input logic f,
                                input logic es, input logic eq, input logic [63:0] ema,
                                input logic cr, input logic [63:0] erd, input logic ee);
        vec_t t;
        t.ren = r; t.addr = a; t.gnt = g; t.rv = v; t.merr = e; t.mdata = d; t.flush = f;
        t.exp_stall = es; t.exp_req = eq; t.exp_maddr = ema;
        t.chk_rd = cr; t.exp_rdata = erd; t.exp_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [63:0] a, input logic g, input logic v,
                         input logic e, input logic [63:0] d, input logic f);
        ptw_ren        = r;
        ptw_addr       = a;
        mif.mem_gnt    = g;
        mif.mem_rvalid = v;
        mif.mem_err    = e;
        mif.mem_rdata  = d;
        flush          = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full miss from IDLE: address cycle, gnt cycle, rvalid cycle, then hit
    task automatic do_miss(input string nm, input logic [63:0] a, input logic [63:0] d);
        next_cycle(); drive(1, a, 0, 0, 0, 0, 0); #2;
        chk({nm, "_stall"}, ptw_stall, 1);
        next_cycle(); drive(1, a, 1, 0, 0, 0, 0); #2;
        chk({nm, "_req"}, mif.mem_req, 1);
        chk({nm, "_maddr"}, mif.mem_addr, a & ~64'h7);
        next_cycle(); drive(1, a, 0, 1, 0, d, 0); #2;
        next_cycle(); drive(1, a, 0, 0, 0, 0, 0); #2;
        chk({nm, "_hit"}, ptw_stall, 0);
        chk({nm, "_rdata"}, ptw_rdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a1, a2, a3, a4, a5, a6, a7, m6, m7;
        logic [63:0] d1, d2, d3, d5, d6, d7;
        logic [63:0] at, af, ar;
        int          to_n;

        a1 = 64'h8000_1008; d1 = 64'h2000_0401;
        a2 = 64'h8000_2010; d2 = 64'h2000_0801;
        a3 = 64'h8000_3018; d3 = 64'h2000_0c01;
        a4 = 64'h8000_4000;
        a5 = 64'h8000_5008; d5 = 64'h2000_1401;
        a6 = 64'h8000_8005; m6 = 64'h8000_8000; d6 = 64'h2000_2001;
        a7 = 64'h8000_900F; m7 = 64'h8000_9008; d7 = 64'h2000_2401;
        at = 64'h8000_6000; af = 64'h8000_7008; ar = 64'h8000_B008;

        // ren addr gnt rv err mdata flush | stall req maddr chk_rd rdata err_pulse
        vecs[0]  = mk(1, a1, 0, 0, 0, 0,  0,  1, 0, 0,  1, 0,  0);
        vecs[1]  = mk(1, a1, 1, 0, 0, 0,  0,  1, 1, a1, 0, 0,  0);
        vecs[2]  = mk(1, a1, 0, 1, 0, d1, 0,  1, 0, 0,  0, 0,  0);
        vecs[3]  = mk(1, a1, 0, 0, 0, 0,  0,  0, 0, 0,  1, d1, 0);
        vecs[4]  = mk(0, a1, 0, 0, 0, 0,  0,  0, 0, 0,  1, d1, 0);
        vecs[5]  = mk(1, a1, 0, 0, 0, 0,  0,  0, 0, 0,  1, d1, 0);
        vecs[6]  = mk(1, a2, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[7]  = mk(1, a2, 1, 0, 0, 0,  0,  1, 1, a2, 0, 0,  0);
        vecs[8]  = mk(1, a2, 0, 1, 0, d2, 0,  1, 0, 0,  0, 0,  0);
        vecs[9]  = mk(1, a2, 0, 0, 0, 0,  0,  0, 0, 0,  1, d2, 0);
        vecs[10] = mk(1, a3, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[11] = mk(1, a3, 1, 0, 0, 0,  0,  1, 1, a3, 0, 0,  0);
        vecs[12] = mk(1, a3, 0, 1, 0, d3, 0,  1, 0, 0,  0, 0,  0);
        vecs[13] = mk(1, a3, 0, 0, 0, 0,  0,  0, 0, 0,  1, d3, 0);
        vecs[14] = mk(1, a4, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[15] = mk(1, a4, 1, 0, 0, 0,  0,  1, 1, a4, 0, 0,  0);
        vecs[16] = mk(1, a4, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, a4, 0, 0, 0, 0,  0,  0, 0, 0,  1, 0,  1);
        vecs[18] = mk(1, a4, 0, 0, 0, 0,  0,  0, 0, 0,  1, 0,  0);
        vecs[19] = mk(1, a5, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[20] = mk(1, a5, 1, 1, 0, d5, 0,  1, 1, a5, 0, 0,  0);
        vecs[21] = mk(1, a5, 0, 0, 0, 0,  0,  0, 0, 0,  1, d5, 0);
        vecs[22] = mk(1, a6, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[23] = mk(1, a7, 1, 0, 0, 0,  0,  1, 1, m6, 0, 0,  0);
        vecs[24] = mk(1, a7, 0, 1, 0, d6, 0,  1, 0, 0,  0, 0,  0);
        vecs[25] = mk(1, a7, 0, 0, 0, 0,  0,  1, 0, 0,  0, 0,  0);
        vecs[26] = mk(1, a7, 1, 0, 0, 0,  0,  1, 1, m7, 0, 0,  0);
        vecs[27] = mk(1, a7, 0, 1, 0, d7, 0,  1, 0, 0,  0, 0,  0);
        vecs[28] = mk(1, a7, 0, 0, 0, 0,  0,  0, 0, 0,  1, d7, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_rdata", ptw_rdata, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_maddr", mif.mem_addr, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_stall", ptw_stall, 0);

        for (int i = 0; i < 29; i++) begin
            next_cycle();
            drive(vecs[i].ren, vecs[i].addr, vecs[i].gnt, vecs[i].rv, vecs[i].merr,
                  vecs[i].mdata, vecs[i].flush);
            #2;
            chk($sformatf("v%0d_stall", i), ptw_stall, vecs[i].exp_stall);
            chk($sformatf("v%0d_req", i), mif.mem_req, vecs[i].exp_req);
            chk($sformatf("v%0d_err", i), err_pulse, vecs[i].exp_err);
            if (vecs[i].exp_req) chk($sformatf("v%0d_maddr", i), mif.mem_addr, vecs[i].exp_maddr);
            if (vecs[i].chk_rd)  chk($sformatf("v%0d_rdata", i), ptw_rdata, vecs[i].exp_rdata);
        end

        // Timeout, then a late response that must be discarded
        next_cycle(); drive(1, at, 0, 0, 0, 0, 0); #2;
        chk("to_stall", ptw_stall, 1);
        next_cycle(); drive(1, at, 1, 0, 0, 0, 0); #2;
        chk("to_req", mif.mem_req, 1);
        to_n = 0;
        for (int i = 1; i <= 400; i++) begin
            next_cycle(); drive(1, at, 0, 0, 0, 0, 0); #2;
            if (err_pulse === 1'b1) begin
                to_n = i;
                break;
            end
        end
        chk("to_latency", 64'(to_n), 256);
        chk("to_stall_after", ptw_stall, 0);
        chk("to_rdata", ptw_rdata, 0);
        next_cycle(); drive(1, at, 0, 1, 0, 64'hDEAD, 0); #2;
        chk("to_pulse_once", err_pulse, 0);
        next_cycle(); drive(1, at, 0, 0, 0, 0, 0); #2;
        chk("to_late_rdata", ptw_rdata, 0);
        chk("to_late_stall", ptw_stall, 0);
        do_miss("to_next", 64'h8000_A000, 64'h2000_2801);

        // Flush mid-WAIT, then flush coinciding with rvalid, then flush in IDLE
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_stall", ptw_stall, 1);
        next_cycle(); drive(1, af, 1, 0, 0, 0, 0); #2;
        chk("fl_req", mif.mem_req, 1);
        next_cycle(); drive(1, af, 0, 0, 0, 0, 1); #2;
        chk("fl_wait_stall", ptw_stall, 1);
        next_cycle(); drive(1, af, 0, 1, 0, 64'h1234, 0); #2;
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_nofill_stall", ptw_stall, 1);
        chk("fl_idle_req", mif.mem_req, 0);
        next_cycle(); drive(1, af, 1, 0, 0, 0, 0); #2;
        chk("fl_rereq", mif.mem_req, 1);
        chk("fl_rereq_maddr", mif.mem_addr, af);
        next_cycle(); drive(1, af, 0, 1, 0, 64'h5678, 1); #2;
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_same_stall", ptw_stall, 1);
        chk("fl_same_req", mif.mem_req, 0);
        next_cycle(); drive(1, af, 1, 0, 0, 0, 0); #2;
        chk("fl_same_rereq", mif.mem_req, 1);
        next_cycle(); drive(1, af, 0, 1, 0, 64'h9ABC, 0); #2;
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_fill_stall", ptw_stall, 0);
        chk("fl_fill_rdata", ptw_rdata, 64'h9ABC);
        next_cycle(); drive(1, af, 0, 0, 0, 0, 1); #2;
        chk("fl_idle_same", ptw_stall, 0);
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_idle_cleared", ptw_stall, 1);
        next_cycle(); drive(1, af, 1, 0, 0, 0, 0); #2;
        chk("fl_idle_req", mif.mem_req, 1);
        next_cycle(); drive(1, af, 0, 1, 0, 64'h1111, 0); #2;
        next_cycle(); drive(1, af, 0, 0, 0, 0, 0); #2;
        chk("fl_idle_rdata", ptw_rdata, 64'h1111);

        // Reset while REQ is pending; stale rvalid in IDLE ignored
        next_cycle(); drive(1, ar, 0, 0, 0, 0, 0); #2;
        chk("rr_stall", ptw_stall, 1);
        next_cycle(); drive(1, ar, 0, 0, 0, 0, 0); rst = 1'b1; #2;
        chk("rr_req", mif.mem_req, 1);
        next_cycle(); rst = 1'b0; drive(1, ar, 0, 1, 0, 64'hBAD, 0); #2;
        chk("rr_req_cleared", mif.mem_req, 0);
        chk("rr_rdata_cleared", ptw_rdata, 0);
        chk("rr_err", err_pulse, 0);
        next_cycle(); drive(1, ar, 1, 0, 0, 0, 0); #2;
        chk("rr_rereq", mif.mem_req, 1);
        chk("rr_maddr", mif.mem_addr, ar);
        next_cycle(); drive(1, ar, 0, 1, 0, 64'h2000_2C01, 0); #2;
        next_cycle(); drive(1, ar, 0, 0, 0, 0, 0); #2;
        chk("rr_fill_stall", ptw_stall, 0);
        chk("rr_fill_rdata", ptw_rdata, 64'h2000_2C01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
